// File: rtl/single_pkg.sv
// single_pkg: shared IEEE-754 single-precision field widths, word type and divider latency
package single_pkg;
  localparam int SINGLE_EXP_W = 8;
  localparam int SINGLE_MAN_W = 23;
  localparam int SINGLE_BIAS = 127;
  localparam int SINGLE_DIV_LATENCY = 50;
  typedef struct packed {
    logic sign;
    logic [SINGLE_EXP_W-1:0] exp;
    logic [SINGLE_MAN_W-1:0] man;
  } single_t;
endpackage

// File: rtl/sync_ram_dp.sv
// sync_ram_dp: DEPTH x W storage with one registered write port and one async read port
module sync_ram_dp #(
  parameter int DEPTH = 8,
  parameter int W = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  // write on the clock edge; contents need no reset because pointers gate visibility
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/single_divide_result_buffer.sv
// single_divide_result_buffer: credit-gated issue into single_divide, tagged result FIFO out; SINGLE_DIV_DBZ_FLAG_EN adds a divide-by-zero flag
module single_divide_result_buffer
  import single_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [7:0]       req_b_exp,
  output logic             div_in_valid,
  input  logic             div_out_valid,
  input  logic [31:0]      div_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic [CNT_W-1:0] occupancy,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);
  logic [CNT_W-1:0] credits, tag_wr_ptr, data_wr_ptr, rd_ptr;
  logic issue, pop, wr;
  single_t rd_c;
`ifdef SINGLE_DIV_DBZ_FLAG_EN
  localparam int TW = TAG_W + 1;
  logic [TW-1:0] tag_wdata, tag_rdata;
  assign tag_wdata = {req_b_exp == 8'd0, req_tag};
  assign out_dbz = out_valid & tag_rdata[TAG_W];
`else
  localparam int TW = TAG_W;
  logic [TW-1:0] tag_wdata, tag_rdata;
  logic unused_b_exp;
  assign unused_b_exp = &{1'b0, req_b_exp};
  assign tag_wdata = req_tag;
  assign out_dbz = 1'b0;
`endif
  assign req_ready = credits != '0;
  assign issue = req_valid & req_ready;
  assign div_in_valid = issue;
  assign wr = div_out_valid & (tag_wr_ptr != data_wr_ptr);
  assign out_valid = data_wr_ptr != rd_ptr;
  assign pop = out_valid & out_ready;
  assign occupancy = data_wr_ptr - rd_ptr;
  assign out_data = out_valid ? rd_c : '0;
  assign out_tag = out_valid ? tag_rdata[TAG_W-1:0] : '0;
  // credit pool, wrap-bit pointers and sticky error for unmatched divider strobes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      credits <= CNT_W'(DEPTH);
      tag_wr_ptr <= '0;
      data_wr_ptr <= '0;
      rd_ptr <= '0;
      err <= 1'b0;
    end else begin
      credits <= credits - CNT_W'(issue) + CNT_W'(pop);
      if (issue) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (wr) data_wr_ptr <= data_wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (div_out_valid & ~wr) err <= 1'b1;
    end
  sync_ram_dp #(.DEPTH(DEPTH), .W(TW)) u_tag_ram (
    .clk(clk), .we(issue), .waddr(tag_wr_ptr[AW-1:0]), .wdata(tag_wdata),
    .raddr(rd_ptr[AW-1:0]), .rdata(tag_rdata)
  );
  sync_ram_dp #(.DEPTH(DEPTH), .W($bits(single_t))) u_data_ram (
    .clk(clk), .we(wr), .waddr(data_wr_ptr[AW-1:0]), .wdata(div_c),
    .raddr(rd_ptr[AW-1:0]), .rdata(rd_c)
  );
endmodule

// File: tb/tb_single_divide_result_buffer.sv
// tb_single_divide_result_buffer: directed checks of credit issue, tagged result ordering, backpressure and error flag
module tb_single_divide_result_buffer;
  import single_pkg::*;
  logic clk = 0, rst = 1;
  logic req_valid = 0, out_ready = 0, inj = 0;
  logic [3:0] req_tag = 0;
  logic [7:0] req_b_exp = 8'h80;
  logic [31:0] req_c = 0;
  logic req_ready, div_in_valid, div_out_valid, out_valid, out_dbz, err;
  logic [31:0] div_c, out_data;
  logic [3:0] out_tag, occupancy;
  logic [SINGLE_DIV_LATENCY-1:0] vpipe;
  logic [31:0] dpipe [SINGLE_DIV_LATENCY];
  int n_chk = 0, n_pass = 0;
  logic [3:0] exp_tag [8] = '{4, 5, 6, 7, 8, 5, 6, 7};
  logic [31:0] exp_data [8] = '{32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007,
                                32'h10000008, 32'h3F800000, 32'h40000000, 32'h3F000000};

  always #5 clk = ~clk;

  single_divide_result_buffer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_b_exp(req_b_exp), .div_in_valid(div_in_valid), .div_out_valid(div_out_valid),
    .div_c(div_c), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_dbz(out_dbz), .occupancy(occupancy), .err(err)
  );

  // fixed-latency in-order divider model sharing rst
  always @(posedge clk or posedge rst)
    if (rst) vpipe <= '0;
    else begin
      vpipe <= {vpipe[SINGLE_DIV_LATENCY-2:0], div_in_valid};
      dpipe[0] <= req_c;
      for (int i = 1; i < SINGLE_DIV_LATENCY; i++) dpipe[i] <= dpipe[i-1];
    end
  assign div_out_valid = vpipe[SINGLE_DIV_LATENCY-1] | inj;
  assign div_c = inj ? 32'hDEADBEEF : dpipe[SINGLE_DIV_LATENCY-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(2);
    rst = 0;
    cyc();
    check("rst_req_ready", req_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_err", err, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_dbz", out_dbz, 0);
    for (int i = 1; i <= 8; i++) begin
      req_valid = 1; req_tag = 4'(i); req_c = 32'h10000000 + i;
      #1 check("fill_div_in_valid", div_in_valid, 1);
      cyc();
    end
    #1 check("full_req_ready", req_ready, 0);
    check("full_no_issue", div_in_valid, 0);
    req_valid = 0;
    cyc(SINGLE_DIV_LATENCY + 2);
    check("full_occupancy", occupancy, 8);
    check("full_out_valid", out_valid, 1);
    check("full_head_tag", out_tag, 1);
    check("full_head_data", out_data, 32'h10000001);
    check("full_err", err, 0);
    out_ready = 1;
    cyc();
    out_ready = 0;
    check("pop1_req_ready", req_ready, 1);
    check("pop1_head_tag", out_tag, 2);
    check("pop1_occupancy", occupancy, 7);
    req_valid = 1; req_tag = 5; req_c = 32'h3F800000; out_ready = 1;
    cyc();
    req_valid = 0; out_ready = 0;
    check("swap_req_ready", req_ready, 1);
    check("swap_head_tag", out_tag, 3);
    check("swap_occupancy", occupancy, 6);
    req_valid = 1; req_tag = 6; req_c = 32'h40000000;
    cyc();
    check("iss6_req_ready", req_ready, 0);
    req_tag = 7; req_c = 32'h3F000000; out_ready = 1;
    #1 check("blocked_div_in_valid", div_in_valid, 0);
    cyc();
    out_ready = 0;
    check("pop_req_ready", req_ready, 1);
    check("pop_occupancy", occupancy, 5);
    cyc();
    req_valid = 0;
    check("iss7_req_ready", req_ready, 0);
    cyc(3);
    check("hold_head_tag", out_tag, 4);
    check("hold_head_data", out_data, 32'h10000004);
    for (int k = 0; k < 8; k++) begin
      int t = 0;
      while (!out_valid && t < 100) begin cyc(); t++; end
      check("drain_out_valid", out_valid, 1);
      check("drain_tag", out_tag, exp_tag[k]);
      check("drain_data", out_data, exp_data[k]);
      check("drain_dbz", out_dbz, 0);
      out_ready = 1;
      cyc();
      out_ready = 0;
    end
    check("empty_out_valid", out_valid, 0);
    check("empty_occupancy", occupancy, 0);
    check("empty_out_data", out_data, 0);
    check("empty_req_ready", req_ready, 1);
    check("empty_err", err, 0);
    inj = 1;
    cyc();
    inj = 0;
    check("orphan_err", err, 1);
    check("orphan_occupancy", occupancy, 0);
    check("orphan_out_valid", out_valid, 0);
    cyc(5);
    check("sticky_err", err, 1);
    rst = 1;
    cyc();
    rst = 0;
    cyc();
    check("rst_clears_err", err, 0);
    check("rst2_req_ready", req_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
